cmd_arbiter: RTL

CMD_ARBITER -- requirements
Module: cmd_arbiter

---
 rtl/cmd_arbiter_pkg.sv | 34 +++
 rtl/cmd_arbiter_buffer.sv | 44 ++++
 rtl/cmd_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cmd_arbiter_pkg.sv
// Shared definitions for the two-requester command arbiter: FSM encoding,
// command codes, timeout default and the round-robin pick.
package cmd_arbiter_pkg;

   localparam int TIMEOUT_DEFAULT = 20;
   localparam int CNT_W           = 5;
   localparam int CMD_W           = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   typedef enum logic [CMD_W-1:0] {
      CMD_NOP    = 3'd0,
      CMD_PWR_UP = 3'd1,
      CMD_CAL    = 3'd2,
      CMD_LOCK   = 3'd3,
      CMD_TRIM   = 3'd4,
      CMD_MEAS   = 3'd5,
      CMD_PWR_DN = 3'd6,
      CMD_RESET  = 3'd7
   } cmd_code_e;

   // On a tie the requester that did not win last time is served.
   function automatic logic pick_grant(input logic full0, input logic full1,
                                       input logic last_grant);
      if (full0 && full1) return ~last_grant;
      return full0 ? 1'b0 : 1'b1;
   endfunction

endpackage

// File: rtl/cmd_arbiter_buffer.sv
// One-entry holding buffer in front of the arbiter; ready depends only on
// the registered full flag, so there is no valid-to-ready path.
module req_buffer
   import cmd_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_i,
   input  logic [CMD_W-1:0] cmd_i,
   input  logic             clear_i,
   output logic             ready_o,
   output logic             full_o,
   output logic [CMD_W-1:0] cmd_o
);

   logic             full_q, full_d;
   logic [CMD_W-1:0] cmd_q, cmd_d;

   always_comb begin
      full_d = full_q;
      cmd_d  = cmd_q;
      if (clear_i) begin
         full_d = 1'b0;
      end else if (valid_i && !full_q) begin
         full_d = 1'b1;
         cmd_d  = cmd_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         cmd_q  <= '0;
      end else begin
         full_q <= full_d;
         cmd_q  <= cmd_d;
      end
   end

   assign ready_o = ~full_q;
   assign full_o  = full_q;
   assign cmd_o   = cmd_q;

endmodule

// File: rtl/cmd_arbiter.sv
// Two-requester round-robin command arbiter driving a single sequencer,
// with a bounded wait for the sequencer's done edge.
//
// state    | meaning
// ST_IDLE  | no command in flight; grant when any buffer is full
// ST_ISSUE | issue_start pulse, issue_cmd presented
// ST_WAIT  | waiting for seq_done rising edge or timeout
// ST_RESP  | one-cycle response pulse to the granted requester
module cmd_arbiter
   import cmd_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   input  logic [2:0] req0_cmd,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [2:0] req1_cmd,
   output logic       req1_ready,
   output logic [2:0] issue_cmd,
   output logic       issue_start,
   input  logic       seq_done,
   output logic       resp0_valid,
   output logic       resp1_valid,
   output logic       resp_err,
   output logic       grant_id,
   output logic       busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   arb_state_e       state_q;
   logic             grant_q, last_grant_q, done_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       issue_cmd_q;
   logic             issue_start_q, resp0_q, resp1_q, resp_err_q;

   logic             full0, full1, clear0, clear1, pick, done_rise;
   logic [2:0]       cmd0, cmd1;

   assign clear0    = (state_q == ST_RESP) && (grant_q == 1'b0);
   assign clear1    = (state_q == ST_RESP) && (grant_q == 1'b1);
   assign pick      = pick_grant(full0, full1, last_grant_q);
   assign done_rise = seq_done && !done_q;

   req_buffer u_buf0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (req0_valid),
      .cmd_i   (req0_cmd),
      .clear_i (clear0),
      .ready_o (req0_ready),
      .full_o  (full0),
      .cmd_o   (cmd0)
   );

   req_buffer u_buf1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (req1_valid),
      .cmd_i   (req1_cmd),
      .clear_i (clear1),
      .ready_o (req1_ready),
      .full_o  (full1),
      .cmd_o   (cmd1)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         grant_q       <= 1'b0;
         last_grant_q  <= 1'b1;
         done_q        <= 1'b1;
         cnt_q         <= '0;
         issue_cmd_q   <= '0;
         issue_start_q <= 1'b0;
         resp0_q       <= 1'b0;
         resp1_q       <= 1'b0;
         resp_err_q    <= 1'b0;
      end else begin
         done_q        <= seq_done;
         issue_start_q <= 1'b0;
         resp0_q       <= 1'b0;
         resp1_q       <= 1'b0;
         resp_err_q    <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (full0 || full1) begin
                  grant_q       <= pick;
                  issue_cmd_q   <= pick ? cmd1 : cmd0;
                  issue_start_q <= 1'b1;
                  state_q       <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cnt_q   <= '0;
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               // A done edge wins over a timeout landing on the same cycle.
               if (done_rise || (cnt_q == CNT_LAST)) begin
                  resp0_q    <= ~grant_q;
                  resp1_q    <= grant_q;
                  resp_err_q <= ~done_rise;
                  state_q    <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_RESP: begin
               last_grant_q <= grant_q;
               state_q      <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign issue_cmd   = issue_cmd_q;
   assign issue_start = issue_start_q;
   assign resp0_valid = resp0_q;
   assign resp1_valid = resp1_q;
   assign resp_err    = resp_err_q;
   assign grant_id    = grant_q;
   assign busy        = (state_q != ST_IDLE);

endmodule
